// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target block: state encoding,
// address/byte widths and the R/W bit values.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } slv_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Conditions one bus line: SYNC_STAGES-deep synchronizer, optional
// stability filter (I2C_SLAVE_GLITCH_FILTER_EN), then a previous-sample
// register producing the level and single-cycle rise/fall events.
// Idle bus level is high, so all line state resets to 1.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   filt;

    // Synchronizer chain; the MSB is the metastability-safe sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= '1;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], din};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] filt_cnt;
    logic             filt_q;

    // Filtered value follows the synchronized line only after FILT_LEN
    // consecutive samples disagree with it; shorter pulses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= 1'b1;
            filt_cnt <= '0;
        end else if (sync_p[SYNC_STAGES-1] == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CNT_W'(FILT_LEN - 1)) begin
            filt_q   <= sync_p[SYNC_STAGES-1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_p[SYNC_STAGES-1];

    // Parameter sanity marker: FILT_LEN only shapes the filtered build.
    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
    end
`endif

    // Previous-sample register; edges are registered so they line up
    // with the level they announce.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= filt;
            rise  <= filt & ~level;
            fall  <= ~filt & level;
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target. Oversamples SCL/SDA on clk, decodes
// START/STOP and address+R/W, receives write bytes and serves read bytes.
// SDA is open-drain (0 or Z). Optional macro: I2C_SLAVE_GLITCH_FILTER_EN
// enables the FILT_LEN stability filter on both lines.
import i2c_pkg::*;

module i2c_slave #(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h78,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rd_req,
    output logic                  busy,
    output logic                  ack_err
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    slv_state_t            state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic                  phase_q, phase_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-2:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] tx_q, tx_d;
    logic                  rw_q, rw_d;
    logic [I2C_BYTE_W-1:0] rx_data_d;
    logic                  rx_valid_d, rd_req_d, busy_d, ack_err_d;
    logic [I2C_BYTE_W-1:0] rx_byte;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // An SCL edge in the same cycle as an SDA edge is a data transition,
    // never a bus condition.
    assign start_evt = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
    assign stop_evt  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    // Next-state and output decode; bus conditions override bit handling.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy;
        ack_err_d  = ack_err;
        rx_byte    = {shift_q, sda_lvl};

        if (start_evt) begin
            state_d   = ADDR;
            bitcnt_d  = '0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            ack_err_d = 1'b0;
        end else if (stop_evt) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte[I2C_BYTE_W-2:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (rx_byte[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                state_d = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (rw_q == RW_READ) begin
                                tx_d     = tx_data;
                                rd_req_d = 1'b1;
                                sda_oe_d = ~tx_data[I2C_BYTE_W-1];
                                bitcnt_d = 3'd1;
                                state_d  = READ;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte[I2C_BYTE_W-2:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                            state_d    = WRITE_ACK;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            bitcnt_d = '0;
                            state_d  = WRITE;
                        end
                    end
                end
                READ: begin
                    // bitcnt counts bits already placed on the bus; wrap to 0
                    // means all eight are out.
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = READ_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[3'd7 - bitcnt_q];
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            ack_err_d = 1'b1;
                            state_d   = WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        tx_d     = tx_data;
                        rd_req_d = 1'b1;
                        sda_oe_d = ~tx_data[I2C_BYTE_W-1];
                        bitcnt_d = 3'd1;
                        state_d  = READ;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Control and visible outputs; reset releases SDA on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            phase_q  <= 1'b0;
            sda_oe_q <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            phase_q  <= phase_d;
            sda_oe_q <= sda_oe_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            rd_req   <= rd_req_d;
            busy     <= busy_d;
            ack_err  <= ack_err_d;
        end
    end

    // Shift/holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        tx_q    <= tx_d;
        rw_q    <= rw_d;
    end

endmodule
